// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_SEND,
    S_RECV,
    S_FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_EARLY_LAST = 2'd1;
  localparam logic [1:0] ERR_NO_LAST    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  localparam logic [7:0] DEF_CFG_WORD = 8'h01;

  // States in which the FFT handshakes are live and the watchdog runs.
  function automatic logic is_active(state_t s);
    return (s == S_CFG) || (s == S_SEND) || (s == S_RECV);
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// The three AXI-Stream channels between the frame sequencer and the FFT core.
interface fft_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output cfg_data, cfg_valid, in_data, in_valid, in_last, out_ready,
    input  cfg_ready, in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  cfg_data, cfg_valid, in_data, in_valid, in_last, out_ready,
    output cfg_ready, in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module frame_ram #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register resets so the outputs it drives have a defined reset value;
  // a same-cycle write to raddr returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of an FFT core: config beat, N-sample input frame,
// N-sample result capture, with framing checks and a handshake watchdog.
//
// state    | meaning
// S_IDLE   | host may load samples; waiting for start
// S_CFG    | config word offered to the FFT
// S_SEND   | streaming sample[idx], in_last on idx == N-1
// S_RECV   | accepting output beats into the result buffer
// S_FINISH | one-cycle done pulse
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter int         N        = 16,
  parameter logic [7:0] CFG_WORD = DEF_CFG_WORD,
  parameter int         TIMEOUT  = 1024,
  localparam int        AW       = $clog2(N)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  fft_frame_ctrl_if.master  fft
);
  localparam int            WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t            state, state_n;
  logic [AW-1:0]     idx, idx_n;
  logic [AW-1:0]     oidx, oidx_n;
  logic [WD_W-1:0]   wd_cnt, wd_n;
  logic              err_set;
  logic [1:0]        err_code_n;

  logic              cfg_valid_q, in_valid_q, in_last_q, out_ready_q;
  logic [DATA_W-1:0] samp_q;
  logic              start_acc, cfg_beat, in_beat, out_beat, any_beat;
  logic              samp_we;

  assign fft.cfg_data  = CFG_WORD;
  assign fft.cfg_valid = cfg_valid_q;
  assign fft.in_data   = samp_q;
  assign fft.in_valid  = in_valid_q;
  assign fft.in_last   = in_last_q;
  assign fft.out_ready = out_ready_q;

  assign start_acc = (state == S_IDLE) && start;
  assign cfg_beat  = (state == S_CFG)  && cfg_valid_q && fft.cfg_ready;
  assign in_beat   = (state == S_SEND) && in_valid_q  && fft.in_ready;
  assign out_beat  = (state == S_RECV) && out_ready_q && fft.out_valid;
  assign any_beat  = cfg_beat || in_beat || out_beat;
  assign samp_we   = wr_en && (state == S_IDLE);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    oidx_n     = oidx;
    wd_n       = wd_cnt;
    err_set    = 1'b0;
    err_code_n = ERR_NONE;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CFG;
          idx_n   = '0;
          oidx_n  = '0;
          wd_n    = WD_LOAD;
        end
      end
      S_CFG: begin
        if (cfg_beat) state_n = S_SEND;
      end
      S_SEND: begin
        if (in_beat) begin
          idx_n = idx + AW'(1);
          if (idx == LAST_IDX) state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (out_beat) begin
          if (oidx == LAST_IDX) begin
            if (fft.out_last) begin
              state_n = S_FINISH;
            end else begin
              state_n    = S_IDLE;
              err_set    = 1'b1;
              err_code_n = ERR_NO_LAST;
            end
          end else if (fft.out_last) begin
            state_n    = S_IDLE;
            err_set    = 1'b1;
            err_code_n = ERR_EARLY_LAST;
          end else begin
            oidx_n = oidx + AW'(1);
          end
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    // Watchdog: down-counter reloaded on every beat, fires at terminal count.
    if (is_active(state)) begin
      if (any_beat) begin
        wd_n = WD_LOAD;
      end else if (wd_cnt == '0) begin
        state_n    = S_IDLE;
        err_set    = 1'b1;
        err_code_n = ERR_TIMEOUT;
      end else begin
        wd_n = wd_cnt - WD_W'(1);
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      idx         <= '0;
      oidx        <= '0;
      wd_cnt      <= '0;
      cfg_valid_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
      out_ready_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      oidx        <= oidx_n;
      wd_cnt      <= wd_n;
      cfg_valid_q <= (state_n == S_CFG);
      in_valid_q  <= (state_n == S_SEND);
      in_last_q   <= (state_n == S_SEND) && (idx_n == LAST_IDX);
      out_ready_q <= (state_n == S_RECV);
      busy        <= is_active(state_n);
      done        <= (state_n == S_FINISH);
      if (start_acc) begin
        error    <= 1'b0;
        err_code <= ERR_NONE;
      end else if (err_set) begin
        error    <= 1'b1;
        err_code <= err_code_n;
      end
    end
  end

  // Reading at idx_n keeps in_data equal to sample[idx] one cycle later,
  // including while the FFT stalls.
  frame_ram #(.DATA_W(DATA_W), .DEPTH(N)) u_sample_buf (
    .clk   (aclk),
    .rst   (areset),
    .we    (samp_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_n),
    .rdata (samp_q)
  );

  frame_ram #(.DATA_W(DATA_W), .DEPTH(N)) u_result_buf (
    .clk   (aclk),
    .rst   (areset),
    .we    (out_beat),
    .waddr (oidx),
    .wdata (fft.out_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: echo-stub FFT, transaction-level model, directed frames.
module tb_fft_frame_ctrl;
  localparam int N   = 16;
  localparam int TMO = 64;

  logic       aclk = 1'b0;
  logic       areset, start, wr_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, error;
  logic [1:0] err_code;

  fft_frame_ctrl_if #(.DATA_W(8)) ifc ();

  fft_frame_ctrl #(.DATA_W(8), .N(N), .CFG_WORD(8'h01), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .start(start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .fft(ifc.master)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] frame [N];
  logic [7:0] sine8 [8] = '{8'h00, 8'h07, 8'h0A, 8'h07, 8'h00, 8'hF9, 8'hF6, 8'hF9};

  // Stub FFT controls and observations
  logic       cfg_ready_en = 1'b1;
  logic       stall_mode   = 1'b0;
  int         last_at      = N - 1;
  logic [7:0] echo_q [$];
  int         ob_stub = 0, in_cnt = 0, stub_cyc = 0, first_beat = 0, last_beat = 0;

  // Echo stub: acts just after each rising edge, values hold to the next edge.
  initial begin
    ifc.cfg_ready = 1'b0; ifc.in_ready = 1'b0;
    ifc.out_valid = 1'b0; ifc.out_last = 1'b0; ifc.out_data = 8'h00;
    forever begin
      @(posedge aclk); #1;
      stub_cyc++;
      ifc.cfg_ready = cfg_ready_en;
      ifc.in_ready  = stall_mode ? !ifc.in_ready : 1'b1;
      if (ifc.in_valid && ifc.in_ready) begin
        echo_q.push_back(ifc.in_data);
        if (in_cnt == 0) first_beat = stub_cyc;
        last_beat = stub_cyc;
        in_cnt++;
      end
      if (ifc.out_ready && echo_q.size() > 0) begin
        ifc.out_valid = 1'b1;
        ifc.out_data  = echo_q.pop_front();
        ifc.out_last  = (ob_stub == last_at);
        ob_stub++;
      end else begin
        ifc.out_valid = 1'b0;
        ifc.out_last  = 1'b0;
      end
    end
  end

  // Model: frame-level rules, compared every cycle at the falling edge.
  logic       mact = 0, exp_busy = 0, exp_done = 0, exp_error = 0;
  logic [1:0] exp_code = 0;
  logic       chk_cfg = 0, chk_first = 0, chk_orun = 0, chk_low = 0;
  logic       prev_stall = 0, prev_last = 0;
  logic [7:0] prev_data = 0;
  logic [7:0] exp_frame [N];
  int         ib = 0, ob = 0, idle = 0;

  task automatic model_err(input logic [1:0] c);
    mact = 0; exp_error = 1; exp_code = c; chk_low = 1;
  endtask

  initial begin
    logic beat, nd;
    forever begin
      @(negedge aclk);
      if (areset) begin
        mact = 0; exp_busy = 0; exp_done = 0; exp_error = 0; exp_code = 0;
        chk_cfg = 0; chk_first = 0; chk_orun = 0; chk_low = 0; prev_stall = 0;
        check("rst_busy", busy, 0);
        check("rst_valids", {ifc.cfg_valid, ifc.in_valid, ifc.in_last, ifc.out_ready}, 0);
        check("rst_in_data", ifc.in_data, 0);
      end else begin
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("error", error, exp_error);
        check("err_code", err_code, exp_code);
        if (chk_cfg) begin
          check("cfg_valid_after_start", ifc.cfg_valid, 1);
          check("cfg_data", ifc.cfg_data, 8'h01);
        end
        if (chk_first) begin
          check("in_valid_after_cfg", ifc.in_valid, 1);
          check("in_data_first", ifc.in_data, exp_frame[0]);
        end
        if (chk_orun) check("out_ready_after_last", {ifc.out_ready, ifc.in_valid}, 2'b10);
        if (chk_low) check("valids_low_after_end", {ifc.cfg_valid, ifc.in_valid, ifc.out_ready}, 0);
        if (prev_stall) begin
          check("stall_hold", {ifc.in_valid, ifc.in_last, ifc.in_data}, {1'b1, prev_last, prev_data});
        end
        chk_cfg = 0; chk_first = 0; chk_orun = 0; chk_low = 0; nd = 0;
        if (!mact) begin
          if (start && !exp_done) begin
            mact = 1; exp_frame = frame; ib = 0; ob = 0; idle = 0;
            exp_error = 0; exp_code = 0; chk_cfg = 1;
          end
        end else begin
          beat = 0;
          if (ifc.cfg_valid && ifc.cfg_ready) begin beat = 1; chk_first = 1; end
          if (ifc.in_valid && ifc.in_ready) begin
            beat = 1;
            check("in_data_order", ifc.in_data, (ib < N) ? exp_frame[ib] : 8'hxx);
            check("in_last_pos", ifc.in_last, (ib == N - 1));
            if (ib == N - 1) chk_orun = 1;
            ib++;
          end
          if (ifc.out_valid && ifc.out_ready) begin
            beat = 1;
            if (ifc.out_last && ob < N - 1) model_err(2'd1);
            else if (ob == N - 1) begin
              if (ifc.out_last) begin mact = 0; nd = 1; end
              else model_err(2'd2);
            end
            ob++;
          end
          if (mact) begin
            idle = beat ? 0 : idle + 1;
            if (idle == TMO) model_err(2'd3);
          end
        end
        prev_stall = mact && ifc.in_valid && !ifc.in_ready;
        prev_data  = ifc.in_data;
        prev_last  = ifc.in_last;
        exp_busy   = mact;
        exp_done   = nd;
      end
    end
  end

  // Directed sequence; acts 2 time units after each rising edge.
  task automatic step();
    @(posedge aclk); #2;
  endtask

  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = frame[i];
      step();
    end
    wr_en = 0;
  endtask

  task automatic flush_stub();
    echo_q.delete(); ob_stub = 0; in_cnt = 0;
  endtask

  task automatic run_frame(input logic poke);
    int cyc;
    flush_stub();
    start = 1; step(); start = 0;
    if (poke) begin
      wr_en = 1; wr_addr = 4'd3; wr_data = 8'h55; start = 1;
      step();
      wr_en = 0; start = 0;
    end
    cyc = 0;
    while (!(done || error) && cyc < 400) begin step(); cyc++; end
    check("frame_end_reached", done || error, 1);
  endtask

  task automatic check_results();
    for (int i = 0; i < N; i++) begin
      rd_addr = 4'(i);
      step();
      check("result_buf", rd_data, frame[i]);
    end
  endtask

  initial begin
    int cnt;
    areset = 1; start = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    repeat (3) step();
    check("reset_cfg_data", ifc.cfg_data, 8'h01);
    check("reset_flags", {busy, done, error, err_code}, 0);
    areset = 0;
    step();

    // Clean frame: sine, echo stub, with ignored start and dropped write mid-frame.
    for (int i = 0; i < N; i++) frame[i] = sine8[i % 8];
    load_frame();
    run_frame(1'b1);
    check("clean_done", done, 1);
    check("clean_in_beats", in_cnt, 16);
    step();
    check("done_one_cycle", done, 0);
    check_results();
    rd_addr = 4'd5; step();
    check("result_5_literal", rd_data, 8'hF9);

    // Stalled input: in_ready toggles every cycle.
    for (int i = 0; i < N; i++) frame[i] = 8'(i * 3 + 1);
    load_frame();
    stall_mode = 1;
    run_frame(1'b0);
    stall_mode = 0;
    check("stall_done", done, 1);
    check("stall_span", last_beat - first_beat, 30);
    check("stall_in_beats", in_cnt, 16);
    step();
    check_results();

    // Early out_last on output beat 9.
    last_at = 9;
    run_frame(1'b0);
    check("early_err", {error, err_code}, {1'b1, 2'd1});
    check("early_busy", busy, 0);
    repeat (3) step();
    check("early_no_done", done, 0);

    // Missing out_last.
    last_at = -1;
    run_frame(1'b0);
    check("nolast_err", {error, err_code}, {1'b1, 2'd2});
    check("nolast_beats", ob_stub, 16);
    last_at = N - 1;
    step();

    // Config never accepted: watchdog.
    cfg_ready_en = 0;
    step();
    flush_stub();
    start = 1; step(); start = 0;
    check("tmo_cfg_valid_up", {ifc.cfg_valid, busy}, 2'b11);
    cnt = 0;
    while (!error && cnt < 200) begin step(); cnt++; end
    check("tmo_cycles", cnt, 64);
    check("tmo_code", err_code, 2'd3);
    check("tmo_cfg_valid_low", {ifc.cfg_valid, busy}, 0);
    cfg_ready_en = 1;
    step();

    // Reset in the middle of SEND, then a clean frame.
    flush_stub();
    start = 1; step(); start = 0;
    cnt = 0;
    while (in_cnt < 5 && cnt < 100) begin step(); cnt++; end
    check("reset_mid_send_reached", in_cnt >= 5, 1);
    areset = 1; #1;
    check("areset_immediate", {ifc.cfg_valid, ifc.in_valid, ifc.in_last, ifc.out_ready, busy}, 0);
    step(); step();
    areset = 0;
    step();
    for (int i = 0; i < N; i++) frame[i] = 8'(8'hA0 + i);
    load_frame();
    run_frame(1'b0);
    check("post_reset_done", {done, error}, 2'b10);
    step();
    check_results();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer that sits in front of the FFT core's three AXI-Stream channels (config, input data, output data). It holds one frame of N samples loaded by the host. On a start pulse it issues the FFT configuration word, streams the frame with a correct `last` marker, and captures the N output samples into a result buffer. It reports completion, and flags framing errors or timeouts, so higher-level logic never drives the FFT handshakes directly.

## Interface
- `DATA_W`, 8: sample width, input and output.
- `N`, 16: frame length; power of two, 4..1024.
- `CFG_WORD`, 8'h01: value driven on the config channel (forward transform).
- `TIMEOUT`, 1024: maximum idle cycles tolerated while waiting on the FFT.
- `aclk` in 1: single clock; all logic on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to run a frame.
- `wr_en` in 1: write strobe into the sample buffer.
- `wr_addr` in log2(N): sample index to write.
- `wr_data` in DATA_W: sample value.
- `rd_addr` in log2(N): result buffer index to read.
- `rd_data` out DATA_W: result sample, one-cycle read latency.
- `busy` out 1: high from an accepted `start` until `done` or `error` is set.
- `done` out 1: one-cycle pulse when a frame completes cleanly.
- `error` out 1: sticky flag; cleared by the next accepted `start`.
- `err_code` out 2: 0 none, 1 early `last`, 2 missing `last`, 3 timeout.
- `cfg_data` out 8, `cfg_valid` out 1, `cfg_ready` in 1: FFT config channel.
- `in_data` out DATA_W, `in_valid` out 1, `in_last` out 1, `in_ready` in 1: FFT input channel.
- `out_data` in DATA_W, `out_valid` in 1, `out_last` in 1, `out_ready` out 1: FFT output channel.

## Operation
- States: IDLE, CFG, SEND, RECV, FINISH.
- IDLE:
  - `start` is accepted → CFG; clears `error` and `err_code`, resets the counters.
  - `wr_en` is honoured only in IDLE; writes in any other state are dropped.
- CFG:
  - `cfg_valid`=1 and `cfg_data`=CFG_WORD.
  - On the `cfg_valid`&`cfg_ready` beat → SEND.
- SEND:
  - `in_data`=sample[idx], `in_valid`=1, `in_last`=(idx==N-1). Samples go out in index order 0..N-1.
  - idx advances only on an `in_valid`&`in_ready` beat.
  - Data and last stay stable while `in_ready`=0.
  - The beat that carries `in_last` → RECV.
- RECV:
  - `out_ready`=1. Each `out_valid` beat writes `out_data` to result[oidx] and increments oidx.
  - `out_last` seen with oidx<N-1 → error, code 1.
  - Beat with oidx==N-1 and `out_last`=0 → error, code 2.
  - Beat with oidx==N-1 and `out_last`=1 → FINISH.
  - Both error cases → IDLE.
- FINISH: `done` pulses once → IDLE.
- Watchdog:
  - Counts cycles in CFG, SEND and RECV with no handshake beat; clears on every beat.
  - Reaching TIMEOUT → error, code 3, → IDLE. All valids and `out_ready` drop the next cycle.
- `start` while busy is ignored.
- Result buffer contents persist until overwritten by the next frame.
- `areset` at any time:
  - Forces IDLE and clears counters and flags.
  - Buffer contents are undefined after reset.

## Timing
- Reset values: `busy`, `done`, `error`, `cfg_valid`, `in_valid`, `in_last` and `out_ready` are 0; `err_code`=0; `cfg_data`=CFG_WORD; `in_data`=0.
- All outputs are registered.
- `start` at cycle t → `cfg_valid`=1 and `busy`=1 at t+1.
- Config beat at cycle c → `in_valid`=1 at c+1, carrying sample 0.
- With `in_ready` held high, SEND takes exactly N cycles, one beat per cycle, no bubbles.
- `out_ready` rises the cycle after the `in_last` beat; output beats are accepted every cycle thereafter.
- The final output beat at cycle f → `done`=1 at f+1 and `busy`=0 at f+1.
- `rd_data` reflects `rd_addr` from the previous cycle. A read in the same cycle as a capture write to the same address returns the old value.

## Structure
- Package `fft_ctrl_pkg`:
  - state enum;
  - err_code constants (ERR_NONE, ERR_EARLY_LAST, ERR_NO_LAST, ERR_TIMEOUT);
  - default CFG_WORD.
- Sub-module `frame_ram`: simple dual-port RAM (1 write, 1 registered read), N×DATA_W. Instantiated twice, once as the sample buffer and once as the result buffer.
- The FSM, counters and watchdog live in the top module.

## Test plan
- Load the 16-sample sine frame (0, 7, 10, 7, 0, -7, -10, -7, repeated), then pulse `start`, with a stub FFT that echoes input to output → 16 input beats, `in_last` only on beat 15; result buffer equals input; `done` asserted for one cycle.
- Toggle `in_ready` low every other cycle → 16 beats over about 32 cycles; data held stable while stalled; no sample skipped or duplicated.
- Stub asserts `out_last` on output beat 9 → `error`=1, `err_code`=1, `done` never asserted, state back in IDLE.
- Stub never asserts `out_last` → `err_code`=2 after beat 15.
- Hold `cfg_ready`=0 with TIMEOUT=64 → `err_code`=3 after 64 cycles; `cfg_valid` low the following cycle.
- Assert `areset` mid-SEND at beat 5 → all valids low immediately and `busy`=0. A subsequent `start` runs a full, clean frame.
